// File: rtl/greater_than.sv
// greater_than: registered magnitude comparator with eq/lt flags, valid strobe and saturating A>B counter
module greater_than #(
    parameter int WIDTH   = 2,
    parameter bit SIGNED  = 1'b0,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               in_valid,
    input  logic               clr_count,
    output logic               F,
    output logic               eq_o,
    output logic               lt_o,
    output logic               out_valid,
    output logic [COUNT_W-1:0] gt_count
);
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gt;
    logic             lt;

    // Flipping both sign bits maps two's-complement order onto unsigned order;
    // scanning LSB to MSB lets the most significant differing bit overwrite the result
    always_comb begin
        a  = SIGNED ? (A ^ MSB) : A;
        b  = SIGNED ? (B ^ MSB) : B;
        gt = 1'b0;
        lt = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i] != b[i]) begin
                gt = a[i];
                lt = b[i];
            end
        end
    end

    // Flags load on accepted operands and hold otherwise; out_valid marks a fresh load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F         <= 1'b0;
            eq_o      <= 1'b0;
            lt_o      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                F    <= gt;
                eq_o <= ~gt & ~lt;
                lt_o <= lt;
            end
        end
    end

    // Saturating count of accepted A>B compares; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gt_count <= '0;
        else if (clr_count)
            gt_count <= '0;
        else if (in_valid && gt && gt_count != '1)
            gt_count <= gt_count + COUNT_W'(1);
    end
endmodule

// File: tb/tb_greater_than.sv
// tb_greater_than: table-driven check of unsigned, signed and narrow-counter comparator instances
module tb_greater_than;
    localparam logic [1:0] LT = 2'd0;
    localparam logic [1:0] EQ = 2'd1;
    localparam logic [1:0] GT = 2'd2;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] ur;
        logic [1:0] sr;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic [1:0] b;
    logic       in_valid;
    logic       clr_count;
    logic       f0, e0, l0, v0;
    logic       f1, e1, l1, v1;
    logic       f2, e2, l2, v2;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] c2;
    int         errors;
    int         checks;
    vec_t       tbl [16];

    greater_than #(.WIDTH(2), .SIGNED(1'b0), .COUNT_W(8)) u_uns (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid), .clr_count(clr_count),
        .F(f0), .eq_o(e0), .lt_o(l0), .out_valid(v0), .gt_count(c0)
    );
    greater_than #(.WIDTH(2), .SIGNED(1'b1), .COUNT_W(8)) u_sgn (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid), .clr_count(clr_count),
        .F(f1), .eq_o(e1), .lt_o(l1), .out_valid(v1), .gt_count(c1)
    );
    greater_than #(.WIDTH(2), .SIGNED(1'b0), .COUNT_W(2)) u_cnt (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid), .clr_count(clr_count),
        .F(f2), .eq_o(e2), .lt_o(l2), .out_valid(v2), .gt_count(c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic f, input logic e, input logic l,
                             input logic v, input logic [1:0] r, input logic ev);
        chk(name, {28'd0, f, e, l, v}, {28'd0, r == GT, r == EQ, r == LT, ev});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] na, input logic [1:0] nb, input logic nv, input logic nc);
        a         = na;
        b         = nb;
        in_valid  = nv;
        clr_count = nc;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        tbl = '{
            '{2'd0, 2'd0, EQ, EQ}, '{2'd0, 2'd1, LT, LT}, '{2'd0, 2'd2, LT, GT}, '{2'd0, 2'd3, LT, GT},
            '{2'd1, 2'd0, GT, GT}, '{2'd1, 2'd1, EQ, EQ}, '{2'd1, 2'd2, LT, GT}, '{2'd1, 2'd3, LT, GT},
            '{2'd2, 2'd0, GT, LT}, '{2'd2, 2'd1, GT, LT}, '{2'd2, 2'd2, EQ, EQ}, '{2'd2, 2'd3, LT, LT},
            '{2'd3, 2'd0, GT, LT}, '{2'd3, 2'd1, GT, LT}, '{2'd3, 2'd2, GT, GT}, '{2'd3, 2'd3, EQ, EQ}
        };
        rst_n = 1'b0;
        drive(2'd0, 2'd0, 1'b0, 1'b0);
        #3;
        chk("reset_flags", {28'd0, f0, e0, l0, v0}, 32'd0);
        chk("reset_count", {22'd0, c0, c2}, 32'd0);
        step;
        step;
        rst_n = 1'b1;
        step;
        chk("post_reset_idle", {20'd0, f0, e0, l0, v0, f1, e1, l1, v1, f2, e2, l2, v2}, 32'd0);

        // Exhaustive 2-bit sweep, one pair per cycle, result visible after the next edge
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].a, tbl[i].b, 1'b1, 1'b0);
            step;
            chk_flags($sformatf("uns_%0d", i), f0, e0, l0, v0, tbl[i].ur, 1'b1);
            chk_flags($sformatf("sgn_%0d", i), f1, e1, l1, v1, tbl[i].sr, 1'b1);
        end
        chk("uns_count", {24'd0, c0}, 32'd6);
        chk("sgn_count", {24'd0, c1}, 32'd6);
        chk("narrow_sat", {30'd0, c2}, 32'd3);

        // Flags hold while in_valid is low; out_valid drops
        drive(2'd3, 2'd1, 1'b1, 1'b0);
        step;
        chk_flags("hold_load", f0, e0, l0, v0, GT, 1'b1);
        drive(2'd0, 2'd3, 1'b0, 1'b0);
        step;
        chk_flags("hold_keep", f0, e0, l0, v0, GT, 1'b0);
        step;
        chk_flags("hold_keep2", f0, e0, l0, v0, GT, 1'b0);

        // Narrow counter: clear, five A>B, then clear beats a simultaneous increment
        drive(2'd0, 2'd0, 1'b0, 1'b1);
        step;
        chk("cnt_clr", {30'd0, c2}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(2'd2, 2'd1, 1'b1, 1'b0);
            step;
            chk($sformatf("cnt_%0d", i), {30'd0, c2}, (i < 3) ? i + 1 : 3);
        end
        drive(2'd2, 2'd1, 1'b1, 1'b1);
        step;
        chk("cnt_clr_prio", {30'd0, c2}, 32'd0);
        drive(2'd0, 2'd1, 1'b1, 1'b0);
        step;
        chk("cnt_no_inc_lt", {30'd0, c2}, 32'd0);

        // Back-to-back alternation
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) drive(2'd2, 2'd1, 1'b1, 1'b0);
            else            drive(2'd1, 2'd2, 1'b1, 1'b0);
            step;
            chk_flags($sformatf("b2b_%0d", i), f0, e0, l0, v0, (i % 2 == 0) ? GT : LT, 1'b1);
        end

        // Asynchronous reset mid-cycle with F=1
        drive(2'd3, 2'd1, 1'b1, 1'b0);
        step;
        chk("pre_async_F", {31'd0, f0}, 32'd1);
        drive(2'd3, 2'd1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_flags", {20'd0, f0, e0, l0, v0, f1, e1, l1, v1, f2, e2, l2, v2}, 32'd0);
        chk("async_count", {14'd0, c0, c1, c2}, 32'd0);
        step;
        rst_n = 1'b1;
        drive(2'd0, 2'd0, 1'b0, 1'b0);
        step;
        chk_flags("after_reset_idle", f0, e0, l0, v0, 2'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/greater_than.md
Name: greater_than

Overview:
Registered magnitude comparator. It compares two WIDTH-bit operands A and B and asserts F when A > B. It also provides equal and less-than flags, a valid strobe, and a saturating count of greater-than results. It sits in datapath control logic wherever a registered "A exceeds B" decision is needed.

Parameters:
WIDTH, 2, operand width in bits (legal range 1 to 32).
SIGNED, 0, 0 means unsigned compare; 1 means two's-complement compare.
COUNT_W, 8, width of the greater-than event counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
A  input  WIDTH  first operand.
B  input  WIDTH  second operand.
in_valid  input  1  operands valid this cycle.
clr_count  input  1  synchronous clear of gt_count.
F  output  1  registered result of A > B.
eq_o  output  1  registered result of A == B.
lt_o  output  1  registered result of A < B.
out_valid  output  1  registered flags are fresh this cycle.
gt_count  output  COUNT_W  number of accepted compares with A > B, saturating.

Behaviour:
- Reset: when rst_n = 0, immediately (no clock needed) force F=0, eq_o=0, lt_o=0, out_valid=0, gt_count=0. Reset release is sampled on the next rising clk edge.
- Compare logic:
  - Combinational, evaluated MSB-first: the first differing bit decides the result.
  - SIGNED=1: invert the MSB of both operands before comparing.
  - Exactly one of gt/eq/lt is true for any operand pair.
- Latency: one cycle.
  - On a rising edge with in_valid=1: F, eq_o and lt_o load the compare of the current A and B, and out_valid goes to 1.
  - On a rising edge with in_valid=0: F, eq_o and lt_o hold their previous values, and out_valid goes to 0.
- No backpressure: a new operand pair is accepted every cycle in_valid=1.
- gt_count:
  - Increments by 1 on every edge where in_valid=1 and A > B.
  - Saturates at 2^COUNT_W-1 and does not wrap.
  - clr_count=1 sets it to 0 on the next edge and takes priority over a simultaneous increment.
- Reset mid-operation: all state clears at once, and any in-flight result is discarded.
- Invariant: when out_valid=1, F+eq_o+lt_o = 1. After reset, before the first accepted compare, all three flags are 0.
- Operands are treated as plain values: X/Z need no special handling, and no internal pipelining beyond the single output register.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with F=1 -> F, eq_o, lt_o, out_valid and gt_count all read 0 immediately, without waiting for a clock edge.
- Exhaustive unsigned sweep (WIDTH=2, SIGNED=0), in_valid=1, {A,B} stepping 0 to 15, one per cycle:
  - F=1 exactly for {A,B} = 4, 8, 9, 12, 13, 14.
  - eq_o=1 for 0, 5, 10, 15.
  - lt_o=1 for the remaining six.
  - Each result appears one cycle after its operands.
  - gt_count ends at 6.
- Hold: A=3, B=1 with in_valid=1, then in_valid=0 with A=0, B=3 -> F stays 1 and out_valid drops to 0.
- Signed (SIGNED=1, WIDTH=2): A=2'b10 (-2), B=2'b01 (1) -> F=0, lt_o=1. A=2'b01, B=2'b11 (-1) -> F=1.
- Counter: COUNT_W=2, five consecutive A>B compares -> gt_count reads 1, 2, 3, 3, 3. Assert clr_count together with a further A>B compare -> gt_count=0.
- Back-to-back: alternate A=2, B=1 and A=1, B=2 every cycle with in_valid=1 -> F toggles 1, 0, 1, 0 with one-cycle latency and out_valid stays 1.
